// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus per-channel debounce for switches.
// Ports: clk, rst (sync, active-high), sw_in[WIDTH] raw levels; sw_out clean
// levels, rise/fall one-cycle strobes, changed = |(rise|fall), evt_count
// (mod-256 count of accepted transitions across all channels).
module sw_debounce #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic [7:0]       evt_count
);

    // Counter only has to reach STABLE_CYCLES-1; keep at least one bit.
    localparam int unsigned CW =
        (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [7:0]       evt_q;
    logic [7:0]       evt_d;

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        evt_d  = evt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            // Any sample matching the clean level restarts the window.
            cnt_d[i] = '0;
            if (s2_q[i] != out_q[i]) begin
                if (cnt_q[i] == LAST) begin
                    out_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                    evt_d     = evt_d + 8'd1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= sw_in;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_out    = out_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign changed   = |(rise_q | fall_q);
    assign evt_count = evt_q;

endmodule
